// File: rtl/prod_accum_pkg.sv
// Shared types, widths and helpers for the product accumulator.
// Imported by the interface, the top level and the testbench.
package prod_accum_pkg;

    localparam int PROD_W = 20;
    localparam int ACC_W  = 28;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Beat counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/prod_accum_if.sv
// Product stream in, frame result out: both valid/ready channels of prod_accum.
// The accumulator is the slave; the producer/consumer side is the master.
interface prod_accum_if;
    import prod_accum_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/prod_accum.sv
// Frame accumulator for 20-bit multiplier products: running sum, saturating beat
// count and sticky wrap flag, with a single registered result buffer.
module prod_accum
    import prod_accum_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    prod_accum_if.slave bus
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_ready_s;
    logic               take_s;
    logic               carry_s;
    logic [ACC_W-1:0]   nxt_s;
    logic [ACC_W-1:0]   prod_ext_s;

    // Ready is forced low during reset so no beat can be taken across it.
    assign in_ready_s = ~rst & (state_q != HOLD);
    assign take_s     = bus.in_valid & in_ready_s;
    assign prod_ext_s = {{(ACC_W-PROD_W){1'b0}}, bus.in_prod};
    assign {carry_s, nxt_s} = {1'b0, acc_q} + {1'b0, prod_ext_s};

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

    // State register and all datapath/result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {ACC_W{1'b0}};
            out_count_q <= {CNT_W{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    // Next-state and datapath updates for IDLE / ACCUM / HOLD.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                acc_d = {ACC_W{1'b0}};
                cnt_d = {CNT_W{1'b0}};
                ovf_d = 1'b0;
                if (take_s && bus.in_last) begin
                    out_sum_d   = prod_ext_s;
                    out_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
                    out_ovf_d   = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end else if (take_s) begin
                    acc_d   = prod_ext_s;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end

            ACCUM: begin
                if (take_s && bus.in_last) begin
                    out_sum_d   = nxt_s;
                    out_count_d = sat_inc(cnt_q);
                    out_ovf_d   = ovf_q | carry_s;
                    out_valid_d = 1'b1;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = {CNT_W{1'b0}};
                    ovf_d       = 1'b0;
                    state_d     = HOLD;
                end else if (take_s) begin
                    acc_d = nxt_s;
                    cnt_d = sat_inc(cnt_q);
                    ovf_d = ovf_q | carry_s;
                end else begin
                    state_d = ACCUM;
                end
            end

            HOLD: begin
                // Always one dead cycle after the result leaves before a new beat.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end

            default: begin
                state_d     = IDLE;
                acc_d       = {ACC_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prod_accum.sv
// Directed table of short frames plus hand-written corner sequences and a
// randomised scoreboard run for prod_accum.
module tb_prod_accum;
    import prod_accum_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   rx_cnt;

    localparam int NRAND = 20;

    prod_accum_if bus_if ();

    prod_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] p [4];
        int          n;
        logic [27:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [27:0] s;
        logic [7:0]  c;
        logic        o;
    } res_t;

    vec_t tbl [5];
    res_t expq [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [19:0] p, input logic l);
        int guard;
        guard = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_prod  = p;
        bus_if.in_last  = l;
        while (!bus_if.in_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (guard >= 200) begin
            errors++;
            $display("FAIL beat_timeout in_ready stuck low, required 1");
        end
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.in_prod  = 20'($urandom);
        bus_if.in_last  = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [27:0] s, input logic [7:0] c, input logic o);
        check({tag, "_valid"}, {63'd0, bus_if.out_valid}, 64'd1);
        check({tag, "_sum"},   {36'd0, bus_if.out_sum},   {36'd0, s});
        check({tag, "_count"}, {56'd0, bus_if.out_count}, {56'd0, c});
        check({tag, "_ovf"},   {63'd0, bus_if.out_ovf},   {63'd0, o});
    endtask

    initial begin
        longint tot;
        logic [27:0] exp_big;
        checks = 0;
        errors = 0;
        rx_cnt = 0;
        rst = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_prod   = 20'd0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b0;

        tbl[0] = '{p: '{20'd100, 20'd200, 20'd300, 20'd0}, n: 3, sum: 28'd600, cnt: 8'd3, ovf: 1'b0};
        tbl[1] = '{p: '{20'hFFFFF, 20'd0, 20'd0, 20'd0}, n: 1, sum: 28'd1048575, cnt: 8'd1, ovf: 1'b0};
        tbl[2] = '{p: '{20'd0, 20'd0, 20'd0, 20'd0}, n: 2, sum: 28'd0, cnt: 8'd2, ovf: 1'b0};
        tbl[3] = '{p: '{20'd1, 20'd2, 20'd3, 20'd4}, n: 4, sum: 28'd10, cnt: 8'd4, ovf: 1'b0};
        tbl[4] = '{p: '{20'hFFFFF, 20'hFFFFF, 20'd2, 20'd0}, n: 3, sum: 28'd2097152, cnt: 8'd3, ovf: 1'b0};

        // Reset state
        #2;
        check("rst_in_ready",  {63'd0, bus_if.in_ready},  64'd0);
        check("rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        check("rst_out_sum",   {36'd0, bus_if.out_sum},   64'd0);
        check("rst_out_count", {56'd0, bus_if.out_count}, 64'd0);
        check("rst_out_ovf",   {63'd0, bus_if.out_ovf},   64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("idle_in_ready", {63'd0, bus_if.in_ready}, 64'd1);

        // Table of short frames, consumer always ready
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < tbl[i].n; b++) begin
                send_beat(tbl[i].p[b], (b == tbl[i].n - 1));
            end
            check_result($sformatf("tbl%0d", i), tbl[i].sum, tbl[i].cnt, tbl[i].ovf);
            check($sformatf("tbl%0d_busy", i), {63'd0, bus_if.in_ready}, 64'd0);
            tick();
            check($sformatf("tbl%0d_drop", i), {63'd0, bus_if.out_valid}, 64'd0);
            check($sformatf("tbl%0d_rdy", i), {63'd0, bus_if.in_ready}, 64'd1);
        end

        // 300 full-scale beats: count saturates, sum wraps, ovf set
        bus_if.out_ready = 1'b0;
        tot = 64'd300 * 64'd1048575;
        exp_big = tot[27:0];
        for (int b = 0; b < 300; b++) begin
            send_beat(20'hFFFFF, (b == 299));
        end
        check_result("big", exp_big, 8'd255, 1'b1);

        // Pending result with upstream pushing: must stall and stay stable
        bus_if.in_valid = 1'b1;
        bus_if.in_prod  = 20'd7;
        bus_if.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("hold%0d_in_ready", k), {63'd0, bus_if.in_ready}, 64'd0);
            check_result($sformatf("hold%0d", k), exp_big, 8'd255, 1'b1);
        end
        bus_if.out_ready = 1'b1;
        tick();
        check("hold_release_valid", {63'd0, bus_if.out_valid}, 64'd0);
        check("hold_release_rdy",   {63'd0, bus_if.in_ready},  64'd1);
        tick();
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
        check_result("clean", 28'd7, 8'd1, 1'b0);
        tick();

        // Reset while a result is pending: out_valid falls without a clock edge
        bus_if.out_ready = 1'b0;
        send_beat(20'd42, 1'b1);
        check_result("pend", 28'd42, 8'd1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        check("arst_in_ready",  {63'd0, bus_if.in_ready},  64'd0);
        check("arst_out_sum",   {36'd0, bus_if.out_sum},   64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Reset mid-frame discards the partial sum
        send_beat(20'd7, 1'b0);
        send_beat(20'd9, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  {63'd0, bus_if.in_ready},  64'd0);
        check("mid_rst_out_valid", {63'd0, bus_if.out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        bus_if.out_ready = 1'b1;
        send_beat(20'd5, 1'b1);
        check_result("after_rst", 28'd5, 8'd1, 1'b0);
        tick();

        // Random frames with random gaps against a reference model
        fork
            begin : producer
                for (int f = 0; f < NRAND; f++) begin
                    int n;
                    logic [19:0] p;
                    longint t;
                    res_t r;
                    logic [19:0] beats [8];
                    n = $urandom_range(1, 8);
                    t = 0;
                    for (int b = 0; b < n; b++) begin
                        p = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
                        beats[b] = p;
                        t = t + longint'(p);
                    end
                    r.s = t[27:0];
                    r.c = (n > 255) ? 8'd255 : 8'(n);
                    r.o = (t > 64'h0FFF_FFFF);
                    expq.push_back(r);
                    for (int b = 0; b < n; b++) begin
                        repeat ($urandom_range(0, 2)) begin
                            bus_if.in_valid = 1'b0;
                            bus_if.in_prod  = 20'($urandom);
                            tick();
                        end
                        send_beat(beats[b], (b == n - 1));
                    end
                end
            end
            begin : consumer
                int cyc;
                logic rdy;
                res_t e;
                cyc = 0;
                while (rx_cnt < NRAND && cyc < 5000) begin
                    rdy = 1'($urandom_range(0, 1));
                    bus_if.out_ready = rdy;
                    if (bus_if.out_valid && rdy) begin
                        if (expq.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra result with empty scoreboard, sum=%0d", bus_if.out_sum);
                        end else begin
                            e = expq.pop_front();
                            check($sformatf("rand%0d_sum", rx_cnt),   {36'd0, bus_if.out_sum},   {36'd0, e.s});
                            check($sformatf("rand%0d_count", rx_cnt), {56'd0, bus_if.out_count}, {56'd0, e.c});
                            check($sformatf("rand%0d_ovf", rx_cnt),   {63'd0, bus_if.out_ovf},   {63'd0, e.o});
                        end
                        rx_cnt++;
                    end
                    tick();
                    cyc++;
                end
            end
        join
        check("rand_frames", 64'(rx_cnt), 64'(NRAND));
        check("rand_leftover", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
